// File: rtl/hdr_writeback.sv
// hdr_writeback: RGB565 (byte-swapped) pixel packer and single-word frame-buffer writer; HDR_DBUF_EN adds a ping-pong buffer and frame_sel.
// Latency: 2 cycles from the 8th accepted hdr_done to wr_req; wr_req pulses at least 3 cycles apart.
// Backpressure: ram_busy stalls the drain in IDLE; a word arriving at a full FIFO is dropped and sets sticky overflow.

module hdr_wb_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_rdy,
  output logic [W-1:0] head_dat,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop_rdy && !empty;
  // a full FIFO still takes a push when the head leaves in the same cycle
  assign do_push  = push_vld && (!full || do_pop);
  assign head_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_dat;
  end
endmodule

module hdr_writeback #(
  parameter logic [24:0] HDR_BASE    = 25'hE1000,
  parameter int unsigned FRAME_WORDS = 38400,
  parameter int unsigned ADDR_STEP   = 4,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hdr_en,
  input  logic         frame_start,
  input  logic         hdr_done,
  input  logic [7:0]   lE_red,
  input  logic [7:0]   lE_green,
  input  logic [7:0]   lE_blue,
  input  logic         ram_busy,
  output logic         wr_req,
  output logic [24:0]  wr_address,
  output logic [127:0] wr_data,
  output logic         frame_written,
  output logic         overflow
`ifdef HDR_DBUF_EN
  ,
  output logic         frame_sel
`endif
);
  localparam int WC_W = $clog2(FRAME_WORDS + 1);
  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(FRAME_WORDS - 1);
  localparam logic [WC_W-1:0] WC_ONE    = WC_W'(1);
  localparam logic [24:0]     STEP      = 25'(ADDR_STEP);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;
  state_t state_q, state_d;

  logic [2:0]      pixel_count;
  logic [127:0]    asm_q, asm_d;
  logic [15:0]     pix;
  logic            take, push, pop, fifo_empty, fifo_full, frame_end;
  logic [127:0]    fifo_head;
  logic [WC_W-1:0] word_count;
  logic [24:0]     start_base, end_base;

  // RGB565 with its two bytes swapped to match the camera layout
  assign pix  = {lE_green[4:2], lE_blue[7:3], lE_red[7:3], lE_green[7:5]};
  assign take = hdr_en && hdr_done;
  assign push = take && !frame_start && (pixel_count == 3'd7);

  always_comb begin
    asm_d = asm_q;
    asm_d[{pixel_count, 4'b0000} +: 16] = pix;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_count <= '0;
      asm_q       <= '0;
    end else if (frame_start) begin
      pixel_count <= take ? 3'd1 : 3'd0;
      asm_q       <= take ? {112'b0, pix} : '0;
    end else if (take) begin
      pixel_count <= pixel_count + 3'd1;
      asm_q       <= asm_d;
    end
  end

  hdr_wb_fifo #(.W(128), .DEPTH(int'(FIFO_DEPTH))) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (frame_start),
    .push_vld (push),
    .push_dat (asm_d),
    .pop_rdy  (pop),
    .head_dat (fifo_head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // a frame_start in IDLE flushes the FIFO, so no word is issued that cycle
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !ram_busy && !frame_start) begin
          pop     = 1'b1;
          state_d = REQ;
        end
      end
      REQ:     state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign frame_end = (state_q == REQ) && !frame_start && (word_count == LAST_WORD);

`ifdef HDR_DBUF_EN
  localparam logic [24:0] ALT_BASE = HDR_BASE + 25'(FRAME_WORDS * ADDR_STEP);
  assign start_base = frame_sel ? ALT_BASE : HDR_BASE;
  assign end_base   = frame_sel ? HDR_BASE : ALT_BASE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            frame_sel <= 1'b0;
    else if (frame_end) frame_sel <= ~frame_sel;
  end
`else
  assign start_base = HDR_BASE;
  assign end_base   = HDR_BASE;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_req        <= 1'b0;
      wr_data       <= '0;
      wr_address    <= HDR_BASE;
      word_count    <= '0;
      frame_written <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_req        <= pop;
      frame_written <= frame_end;
      if (pop) wr_data <= fifo_head;
      if (push && fifo_full && !pop) overflow <= 1'b1;
      if (frame_start) begin
        wr_address <= start_base;
        word_count <= '0;
      end else if (frame_end) begin
        wr_address <= end_base;
        word_count <= '0;
      end else if (state_q == REQ) begin
        wr_address <= wr_address + STEP;
        word_count <= word_count + WC_ONE;
      end
    end
  end
endmodule

// File: tb/tb_hdr_writeback.sv
// Bench for hdr_writeback: directed vectors for the corner cases plus random traffic against a queue-based model.
module tb_hdr_writeback;
  localparam int          FW    = 3;
  localparam int          DEPTH = 4;
  localparam logic [24:0] BASE  = 25'hE1000;
  localparam logic [24:0] ALT   = 25'hE100C;
`ifdef HDR_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  logic         clk = 1'b0, rst = 1'b1;
  logic         hdr_en = 1'b0, frame_start = 1'b0, hdr_done = 1'b0, ram_busy = 1'b0;
  logic [7:0]   lE_red = '0, lE_green = '0, lE_blue = '0;
  logic         wr_req, frame_written, overflow;
  logic [24:0]  wr_address;
  logic [127:0] wr_data;
`ifdef HDR_DBUF_EN
  logic         frame_sel;
`endif

  always #5 clk = ~clk;

  hdr_writeback #(.FRAME_WORDS(FW)) dut (
    .clk           (clk),
    .rst           (rst),
    .hdr_en        (hdr_en),
    .frame_start   (frame_start),
    .hdr_done      (hdr_done),
    .lE_red        (lE_red),
    .lE_green      (lE_green),
    .lE_blue       (lE_blue),
    .ram_busy      (ram_busy),
    .wr_req        (wr_req),
    .wr_address    (wr_address),
    .wr_data       (wr_data),
    .frame_written (frame_written),
    .overflow      (overflow)
`ifdef HDR_DBUF_EN
    ,
    .frame_sel     (frame_sel)
`endif
  );

  int n_pass = 0, n_total = 0, cyc = 0;
  int           req_cyc[$];
  logic [24:0]  req_addr[$];
  logic [127:0] req_dat[$];
  int           fw_cyc[$];

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endfunction

  // ---------------- reference model ----------------
  logic [15:0]  m_pix[$];
  logic [127:0] m_fifo[$];
  int           m_gap = 2, m_idx = 0;
  bit           m_sel = 0, m_req = 0, m_fw = 0, m_ovf = 0;
  logic [127:0] m_dat = '0;

  function automatic logic [15:0] rgb565_swapped(logic [7:0] r, logic [7:0] g, logic [7:0] b);
    int rr = int'(r) / 8;
    int gg = int'(g) / 4;
    int bb = int'(b) / 8;
    int lo = rr * 8 + gg / 8;
    int hi = (gg % 8) * 32 + bb;
    return 16'(hi * 256 + lo);
  endfunction

  function automatic logic [24:0] m_addr();
    logic [24:0] b = (DBUF && m_sel) ? ALT : BASE;
    return b + 25'(m_idx * 4);
  endfunction

  task automatic m_reset();
    m_pix.delete(); m_fifo.delete();
    m_gap = 2; m_idx = 0; m_sel = 0; m_req = 0; m_fw = 0; m_ovf = 0; m_dat = '0;
  endtask

  // m_gap counts clock edges since the edge that issued the last request
  task automatic m_step();
    bit fs, take, pop;
    logic [127:0] w;
    fs   = frame_start;
    take = hdr_en && hdr_done;
    pop  = (m_fifo.size() > 0) && !ram_busy && !fs && (m_gap >= 2);
    m_fw = 0;
    if (fs) m_idx = 0;
    else if (m_gap == 0) begin
      m_idx++;
      if (m_idx == FW) begin m_idx = 0; m_fw = 1; m_sel = ~m_sel; end
    end
    m_gap = pop ? 0 : ((m_gap < 2) ? m_gap + 1 : 2);
    m_req = pop;
    if (pop) m_dat = m_fifo.pop_front();
    if (fs) begin m_fifo.delete(); m_pix.delete(); end
    if (take) begin
      m_pix.push_back(rgb565_swapped(lE_red, lE_green, lE_blue));
      if (m_pix.size() == 8) begin
        w = '0;
        for (int k = 0; k < 8; k++) w = w | (128'(m_pix[k]) << (16 * k));
        m_pix.delete();
        if (m_fifo.size() < DEPTH) m_fifo.push_back(w);
        else m_ovf = 1;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) m_reset();
    else     m_step();
  end

  // ---------------- monitor ----------------
  task automatic monitor();
    forever begin
      @(negedge clk);
      cyc++;
      if (wr_req === 1'b1) begin
        req_cyc.push_back(cyc); req_addr.push_back(wr_address); req_dat.push_back(wr_data);
      end
      if (frame_written === 1'b1) fw_cyc.push_back(cyc);
      if (!rst) begin
        check("wr_req", 128'(wr_req), 128'(m_req));
        check("frame_written", 128'(frame_written), 128'(m_fw));
        check("overflow", 128'(overflow), 128'(m_ovf));
        check("wr_address", 128'(wr_address), 128'(m_addr()));
        check("wr_data", wr_data, m_dat);
`ifdef HDR_DBUF_EN
        check("frame_sel", 128'(frame_sel), 128'(m_sel));
`endif
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    @(negedge clk);
    hdr_en = 1'b1; hdr_done = 1'b1; frame_start = 1'b0;
    lE_red = r; lE_green = g; lE_blue = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      hdr_done = 1'b0; frame_start = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    hdr_done = 1'b0; frame_start = 1'b0; ram_busy = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic await_req(output int n);
    n = 0;
    do begin
      @(negedge clk);
      hdr_done = 1'b0; frame_start = 1'b0;
      n++;
    end while (wr_req !== 1'b1 && n < 20);
  endtask

  task automatic clear_log();
    req_cyc.delete(); req_addr.delete(); req_dat.delete(); fw_cyc.delete();
  endtask

  task automatic check_reset_values(string tag);
    check({tag, " wr_req"}, 128'(wr_req), 128'(0));
    check({tag, " wr_address"}, 128'(wr_address), 128'(BASE));
    check({tag, " wr_data"}, wr_data, 128'(0));
    check({tag, " frame_written"}, 128'(frame_written), 128'(0));
    check({tag, " overflow"}, 128'(overflow), 128'(0));
`ifdef HDR_DBUF_EN
    check({tag, " frame_sel"}, 128'(frame_sel), 128'(0));
`endif
  endtask

  typedef struct {
    logic [7:0]  r, g, b;
    logic [15:0] exp;
  } vec_t;

  initial begin
    vec_t        tbl[8];
    int          n;
    logic [15:0] p16;
    logic [24:0] ea;

    tbl[0] = '{8'hF8, 8'hFC, 8'hF8, 16'hFFFF};
    tbl[1] = '{8'h08, 8'h04, 8'h00, 16'h2008};
    tbl[2] = '{8'h00, 8'h00, 8'h00, 16'h0000};
    tbl[3] = '{8'hFF, 8'h00, 8'h00, 16'h00F8};
    tbl[4] = '{8'h00, 8'hFF, 8'h00, 16'hE007};
    tbl[5] = '{8'h00, 8'h00, 8'hFF, 16'h1F00};
    tbl[6] = '{8'h12, 8'h34, 8'h56, 16'hAA11};
    tbl[7] = '{8'h80, 8'h20, 8'h07, 16'h0081};

    fork monitor(); join_none

    // reset values, then first-word latency
    do_reset();
    check_reset_values("reset");
    for (int k = 0; k < 8; k++) pix(8'hF8, 8'hFC, 8'hF8);
    await_req(n);
    check("latency", 128'(n), 128'(2));
    check("first addr", 128'(wr_address), 128'(BASE));
    check("first data", wr_data, {128{1'b1}});

    // single nonzero pixel in slot 0
    pix(8'h08, 8'h04, 8'h00);
    for (int k = 1; k < 8; k++) pix(8'h00, 8'h00, 8'h00);
    await_req(n);
    check("slot0 data", wr_data, 128'h2008);

    // conversion table, one entry per slot
    for (int k = 0; k < 8; k++) pix(tbl[k].r, tbl[k].g, tbl[k].b);
    await_req(n);
    for (int k = 0; k < 8; k++) check($sformatf("tbl slot%0d", k), 128'(wr_data[16*k +: 16]), 128'(tbl[k].exp));

    // five words against a stalled RAM: one dropped, then drained at 3-cycle spacing
    do_reset();
    ram_busy = 1'b1;
    for (int w = 0; w < 5; w++)
      for (int k = 0; k < 8; k++) pix(8'(8 * (w + 1)), 8'h00, 8'h00);
    idle(3);
    check("overflow set", 128'(overflow), 128'(1));
    check("no req while busy", 128'(wr_req), 128'(0));
    clear_log();
    ram_busy = 1'b0;
    idle(25);
    check("drain count", 128'(req_cyc.size()), 128'(4));
    if (req_cyc.size() >= 4) begin
      for (int k = 0; k < 4; k++) begin
        ea  = (k < 3) ? BASE + 25'(4 * k) : (DBUF ? ALT : BASE);
        p16 = 16'(8 * (k + 1));
        check($sformatf("drain addr%0d", k), 128'(req_addr[k]), 128'(ea));
        check($sformatf("drain data%0d", k), req_dat[k], {8{p16}});
        if (k > 0) check($sformatf("drain gap%0d", k), 128'(req_cyc[k] - req_cyc[k-1]), 128'(3));
      end
      check("frame_written count", 128'(fw_cyc.size()), 128'(1));
      if (fw_cyc.size() >= 1) check("frame_written cycle", 128'(fw_cyc[0]), 128'(req_cyc[2] + 1));
    end
`ifdef HDR_DBUF_EN
    check("frame_sel after frame", 128'(frame_sel), 128'(1));
`endif

    // asynchronous reset while two words are queued
    ram_busy = 1'b1;
    for (int k = 0; k < 16; k++) pix(8'hA0, 8'h50, 8'h28);
    idle(2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_values("async rst");
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    ram_busy = 1'b0;
    clear_log();
    idle(15);
    check("no req after rst", 128'(req_cyc.size()), 128'(0));

    // frame_start discards a partial word
    do_reset();
    clear_log();
    for (int k = 0; k < 5; k++) pix(8'hF8, 8'hFC, 8'hF8);
    @(negedge clk);
    hdr_done = 1'b0; frame_start = 1'b1;
    for (int k = 0; k < 8; k++) pix(8'h08, 8'h04, 8'h00);
    idle(20);
    check("fs req count", 128'(req_cyc.size()), 128'(1));
    if (req_cyc.size() >= 1) begin
      check("fs addr", 128'(req_addr[0]), 128'(BASE));
      check("fs data", req_dat[0], {8{16'h2008}});
    end

    // random traffic, light then heavy backpressure
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      hdr_en      = ($urandom_range(0, 9) != 0);
      hdr_done    = ($urandom_range(0, 1) == 1);
      ram_busy    = ($urandom_range(0, 4) < 2);
      frame_start = ($urandom_range(0, 149) == 0);
      lE_red      = 8'($urandom); lE_green = 8'($urandom); lE_blue = 8'($urandom);
    end
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      hdr_en      = 1'b1;
      hdr_done    = ($urandom_range(0, 3) != 0);
      ram_busy    = ($urandom_range(0, 9) != 0);
      frame_start = ($urandom_range(0, 99) == 0);
      lE_red      = 8'($urandom); lE_green = 8'($urandom); lE_blue = 8'($urandom);
    end
    ram_busy = 1'b0;
    idle(40);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
